imm_extend_seq: RTL and testbench

//  Parametrised, handshaked successor of the single-cycle immediate extender.
//  - Adds ARM rotated data-processing immediates, computed iteratively (ROT_STEP bits per cycle).
//  - Adds halfword-offset immediates and the shifter carry-out.
//  - Sits between decode and the ALU/address path of the multi-cycle core.
//  - Valid/ready on both sides allows operand fetch to stall it.

---
 rtl/imm_ext_pkg.sv | 31 +++
 rtl/imm_rot_step.sv | 20 ++
 rtl/imm_extend_seq.sv | 133 +++++++++++++
 tb/tb_imm_extend_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pkg
//  Description : Shared encodings, FSM state type and helpers for the
//                sequential immediate extender.
//  Revision    : 1.0  initial release
// ============================================================================
package imm_ext_pkg;

  // imm_src encodings
  localparam logic [1:0] IMM_DP    = 2'b00;  // ARM rotated data-processing immediate
  localparam logic [1:0] IMM_MEM12 = 2'b01;  // 12-bit memory offset
  localparam logic [1:0] IMM_BR    = 2'b10;  // 24-bit branch offset, word aligned
  localparam logic [1:0] IMM_MEMH8 = 2'b11;  // split 8-bit halfword offset

  // Width of the remaining-rotation counter (rotations are 0..30)
  localparam int unsigned REM_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Rotate distance of a DP immediate: twice the 4-bit rotate field
  function automatic logic [REM_W-1:0] dp_rem(input logic [3:0] rot_field);
    return {rot_field, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_rot_step.sv
`default_nettype none
// ============================================================================
//  Module      : imm_rot_step
//  Description : Combinational 32-bit rotate-right by 0..31 bits; one slice
//                of the iterative DP-immediate rotation.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_rot_step (
  input  logic [31:0] data_i,
  input  logic [4:0]  amt_i,
  output logic [31:0] data_o
);

  // A left shift of 32 yields zero, so amt_i == 0 degenerates to identity
  always_comb begin
    data_o = (data_i >> amt_i) | (data_i << (6'd32 - {1'b0, amt_i}));
  end

endmodule
`default_nettype wire

// File: rtl/imm_extend_seq.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend_seq
//  Description : Handshaked immediate extender. DP immediates are rotated
//                iteratively, ROT_STEP bits per cycle; other modes complete
//                in one cycle. Result is held until the consumer takes it.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_extend_seq #(
  parameter int DATA_W   = 32,  // 32 or 64
  parameter int ROT_STEP = 2    // power of two, 2..32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       instr,
  input  logic [1:0]        imm_src,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic              carry_out
);

  import imm_ext_pkg::*;

  localparam logic [5:0] STEP_W6 = 6'(ROT_STEP);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               carry_q, carry_d;

  logic               accept;
  logic [DATA_W-1:0]  load_val;
  logic [REM_W-1:0]   load_rem;
  logic [REM_W-1:0]   step_amt;
  logic [31:0]        rot_res;

  // Ready is forced low while reset is held so nothing is taken mid-reset
  assign in_ready  = !reset && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign ext_imm   = acc_q;
  assign carry_out = carry_q;

  // Extended value loaded on accept; DP loads the unrotated byte
  always_comb begin
    load_val = '0;
    load_rem = '0;
    unique case (imm_src)
      IMM_DP: begin
        load_val = {{(DATA_W-8){1'b0}}, instr[7:0]};
        load_rem = dp_rem(instr[11:8]);
      end
      IMM_MEM12: load_val = {{(DATA_W-12){1'b0}}, instr[11:0]};
      IMM_BR:    load_val = {{(DATA_W-26){instr[23]}}, instr[23:0], 2'b00};
      IMM_MEMH8: load_val = {{(DATA_W-8){1'b0}}, instr[11:8], instr[3:0]};
      default:   load_val = '0;
    endcase
  end

  // Per-cycle rotate distance: the remainder, capped at ROT_STEP
  always_comb begin
    if ({1'b0, rem_q} > STEP_W6) begin
      step_amt = STEP_W6[REM_W-1:0];
    end else begin
      step_amt = rem_q;
    end
  end

  imm_rot_step u_rot_step (
    .data_i (acc_q[31:0]),
    .amt_i  (step_amt),
    .data_o (rot_res)
  );

  // Next-state logic: rotate in ROT, retire from HOLD, load on accept
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      ROT: begin
        // DP results are zero above bit 31 in the wide build
        acc_d        = '0;
        acc_d[31:0]  = rot_res;
        rem_d        = rem_q - step_amt;
        if (rem_d == '0) begin
          state_d = HOLD;
          carry_d = rot_res[31];
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Accept overrides: covers both IDLE and back-to-back from HOLD
    if (accept) begin
      acc_d = load_val;
      rem_d = load_rem;
      if (load_rem == '0) begin
        state_d = HOLD;
        carry_d = carry_in;
      end else begin
        state_d = ROT;
      end
    end
  end

  // State, accumulator, rotate counter and carry registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_extend_seq
//  Description : Self-checking bench for imm_extend_seq; four builds
//                (32/2, 64/2, 32/32, 32/8) share the input buses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_extend_seq;

  import imm_ext_pkg::*;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [23:0] instr    = '0;
  logic [1:0]  imm_src  = '0;
  logic        carry_in = 1'b0;
  logic [3:0]  iv       = '0;
  logic [3:0]  ordy     = '0;
  wire  [3:0]  irdy;
  wire  [3:0]  ov;
  wire  [3:0]  co;
  wire  [31:0] e0, e2, e3;
  wire  [63:0] e1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_extend_seq #(.DATA_W(32), .ROT_STEP(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]),
    .instr(instr), .imm_src(imm_src), .carry_in(carry_in),
    .out_valid(ov[0]), .out_ready(ordy[0]), .ext_imm(e0), .carry_out(co[0]));

  imm_extend_seq #(.DATA_W(64), .ROT_STEP(2)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]),
    .instr(instr), .imm_src(imm_src), .carry_in(carry_in),
    .out_valid(ov[1]), .out_ready(ordy[1]), .ext_imm(e1), .carry_out(co[1]));

  imm_extend_seq #(.DATA_W(32), .ROT_STEP(32)) u_dut_s32 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]),
    .instr(instr), .imm_src(imm_src), .carry_in(carry_in),
    .out_valid(ov[2]), .out_ready(ordy[2]), .ext_imm(e2), .carry_out(co[2]));

  imm_extend_seq #(.DATA_W(32), .ROT_STEP(8)) u_dut_s8 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(irdy[3]),
    .instr(instr), .imm_src(imm_src), .carry_in(carry_in),
    .out_valid(ov[3]), .out_ready(ordy[3]), .ext_imm(e3), .carry_out(co[3]));

  function automatic logic [63:0] imm_of(input int idx);
    case (idx)
      0:       return {32'h0, e0};
      1:       return e1;
      2:       return {32'h0, e2};
      default: return {32'h0, e3};
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror_bitwise(input logic [31:0] v, input int n);
    logic [31:0] x;
    x = v;
    for (int k = 0; k < n; k++) x = {x[0], x[31:1]};
    return x;
  endfunction

  function automatic logic [63:0] model_imm(input int dw, input logic [23:0] ins,
                                            input logic [1:0] src);
    longint v;
    case (src)
      2'b00: return {32'h0, ror_bitwise({24'h0, ins[7:0]}, 2 * int'(ins[11:8]))};
      2'b01: return {52'h0, ins[11:0]};
      2'b11: return {56'h0, ins[11:8], ins[3:0]};
      default: begin
        v = longint'(ins);
        if (ins[23]) v = v - 64'sd16777216;
        v = v * 4;
        if (dw == 32) return 64'(v) & 64'hFFFF_FFFF;
        return 64'(v);
      end
    endcase
  endfunction

  function automatic logic model_carry(input logic [23:0] ins, input logic [1:0] src,
                                       input logic cin);
    logic [31:0] x;
    if (src != 2'b00 || ins[11:8] == 4'h0) return cin;
    x = ror_bitwise({24'h0, ins[7:0]}, 2 * int'(ins[11:8]));
    return x[31];
  endfunction

  function automatic int model_lat(input logic [23:0] ins, input logic [1:0] src,
                                   input int rs);
    int r;
    if (src != 2'b00) return 1;
    r = 2 * int'(ins[11:8]);
    return 1 + (r + rs - 1) / rs;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Push one item into build idx, measure latency, hold for `stall` cycles, pop
  task automatic run_one(input int idx, input logic [23:0] ins, input logic [1:0] src,
                         input logic cin, input int stall,
                         output logic [63:0] imm, output logic c, output int lat);
    int n;
    instr    = ins;
    imm_src  = src;
    carry_in = cin;
    iv[idx]  = 1'b1;
    ordy[idx] = 1'b0;
    n = 0;
    while (!irdy[idx] && n < 50) begin
      step();
      n++;
    end
    check1("accept_ready", irdy[idx], 1'b1);
    step();
    iv[idx]  = 1'b0;
    // Scramble inputs: the block must have sampled them at accept only
    instr    = 24'($urandom);
    imm_src  = 2'($urandom);
    carry_in = 1'($urandom);
    lat = 1;
    while (!ov[idx] && lat < 200) begin
      step();
      lat++;
    end
    imm = imm_of(idx);
    c   = co[idx];
    for (int s = 0; s < stall; s++) begin
      step();
      check("hold_stable", imm_of(idx), imm);
      check1("hold_valid", ov[idx], 1'b1);
    end
    ordy[idx] = 1'b1;
    step();
    ordy[idx] = 1'b0;
    check1("pop_idle", ov[idx], 1'b0);
  endtask

  typedef struct {
    string       nm;
    logic [23:0] ins;
    logic [1:0]  src;
    logic        cin;
    logic [31:0] exp;
    logic        c;
    int          lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] imm;
    logic        c;
    int          lat;
    int          idx, dw, rs, stall;
    logic [23:0] ins;
    logic [1:0]  src;
    logic        cin;

    tbl[0] = '{"dp_rot4",   24'h0004FF, IMM_DP,    1'b0, 32'hFF000000, 1'b1, 5};
    tbl[1] = '{"dp_rot0",   24'h0000A5, IMM_DP,    1'b1, 32'h000000A5, 1'b1, 1};
    tbl[2] = '{"dp_rot15",  24'h000F01, IMM_DP,    1'b1, 32'h00000004, 1'b0, 16};
    tbl[3] = '{"mem12",     24'h000ABC, IMM_MEM12, 1'b0, 32'h00000ABC, 1'b0, 1};
    tbl[4] = '{"branch",    24'h800001, IMM_BR,    1'b1, 32'hFE000004, 1'b1, 1};
    tbl[5] = '{"memh8",     24'h000F0A, IMM_MEMH8, 1'b0, 32'h000000FA, 1'b0, 1};

    // Reset state
    step();
    step();
    check1("rst_in_ready", irdy[0], 1'b0);
    check1("rst_out_valid", ov[0], 1'b0);
    check("rst_ext_imm", {32'h0, e0}, 64'h0);
    check1("rst_carry", co[0], 1'b0);
    reset = 1'b0;
    step();
    check1("post_rst_in_ready", irdy[0], 1'b1);

    // Directed vectors on the 32-bit / step-2 build
    foreach (tbl[i]) begin
      run_one(0, tbl[i].ins, tbl[i].src, tbl[i].cin, 1, imm, c, lat);
      check({tbl[i].nm, "_imm"}, imm, {32'h0, tbl[i].exp});
      check1({tbl[i].nm, "_carry"}, c, tbl[i].c);
      check({tbl[i].nm, "_lat"}, 64'(lat), 64'(tbl[i].lat));
    end

    // Back-to-back MEM12 with consumer always ready
    ordy[0]  = 1'b1;
    iv[0]    = 1'b1;
    imm_src  = IMM_MEM12;
    carry_in = 1'b0;
    instr    = 24'h000100;
    for (int k = 0; k < 4; k++) begin
      check1("b2b_in_ready", irdy[0], 1'b1);
      step();
      check1("b2b_out_valid", ov[0], 1'b1);
      check("b2b_data", {32'h0, e0}, 64'h100 + 64'(k));
      instr = 24'h000100 + 24'(k + 1);
    end
    iv[0] = 1'b0;
    step();
    check1("b2b_drain", ov[0], 1'b0);
    ordy[0] = 1'b0;

    // Consumer stall: result stable, no second accept
    iv[0]   = 1'b1;
    instr   = 24'h000123;
    imm_src = IMM_MEM12;
    step();
    instr = 24'h000456;
    for (int k = 0; k < 3; k++) begin
      check1("stall_in_ready", irdy[0], 1'b0);
      check1("stall_out_valid", ov[0], 1'b1);
      step();
      check("stall_data", {32'h0, e0}, 64'h123);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    step();
    check1("stall_release", ov[0], 1'b0);
    ordy[0] = 1'b0;

    // Reset two cycles into rotation discards the item
    iv[0]    = 1'b1;
    instr    = 24'h0004FF;
    imm_src  = IMM_DP;
    carry_in = 1'b0;
    step();
    iv[0] = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check1("midrot_rst_valid", ov[0], 1'b0);
    check("midrot_rst_imm", {32'h0, e0}, 64'h0);
    check1("midrot_rst_ready", irdy[0], 1'b0);
    check1("midrot_rst_carry", co[0], 1'b0);
    reset = 1'b0;
    step();
    run_one(0, 24'h0004FF, IMM_DP, 1'b0, 0, imm, c, lat);
    check("after_rst_imm", imm, 64'hFF000000);
    check1("after_rst_carry", c, 1'b1);
    check("after_rst_lat", 64'(lat), 64'd5);

    // Other builds
    run_one(2, 24'h0004FF, IMM_DP, 1'b0, 0, imm, c, lat);
    check("s32_imm", imm, 64'hFF000000);
    check("s32_lat", 64'(lat), 64'd2);
    run_one(3, 24'h000F01, IMM_DP, 1'b0, 0, imm, c, lat);
    check("s8_imm", imm, 64'h4);
    check("s8_lat", 64'(lat), 64'd5);
    run_one(1, 24'h800001, IMM_BR, 1'b0, 0, imm, c, lat);
    check("w64_branch", imm, 64'hFFFFFFFFFE000004);

    // Randomized items across all builds against the model
    for (int i = 0; i < 48; i++) begin
      idx   = i % 4;
      dw    = (idx == 1) ? 64 : 32;
      rs    = (idx == 2) ? 32 : ((idx == 3) ? 8 : 2);
      ins   = 24'($urandom);
      src   = 2'($urandom);
      cin   = 1'($urandom);
      stall = int'($urandom_range(0, 2));
      run_one(idx, ins, src, cin, stall, imm, c, lat);
      check("rnd_imm", imm, model_imm(dw, ins, src));
      check1("rnd_carry", c, model_carry(ins, src, cin));
      check("rnd_lat", 64'(lat), 64'(model_lat(ins, src, rs)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
